// File: rtl/projection_pkg.sv
// Shared fixed-point constants, point-record layout and sweep FSM states for
// the projection stream.
package projection_pkg;
  localparam int FRAC_BITS = 8;
  localparam int ONE       = 1 << FRAC_BITS;

  localparam int N_BASIS_DEF  = 3;
  localparam int SCALAR_W_DEF = 16;
  localparam int COLOR_W_DEF  = 4;

  typedef struct packed {
    logic [N_BASIS_DEF-1:0][SCALAR_W_DEF-1:0] scalars;
    logic [COLOR_W_DEF-1:0]                   color;
  } point_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/projection_stream_if.sv
// Projected-point stream towards line_gen.
// A beat transfers on a clock edge where valid_out && ready_in; while valid_out
// is high and ready_in low the master holds every payload field stable.
interface projection_stream_if #(
  parameter int COORD_W = 32,
  parameter int COLOR_W = 4
);
  logic signed [COORD_W-1:0] x_proj;
  logic signed [COORD_W-1:0] y_proj;
  logic [COLOR_W-1:0]        color_proj;
  logic                      on_screen_out;
  logic                      last_out;
  logic                      valid_out;
  logic                      ready_in;

  modport master (output x_proj, y_proj, color_proj, on_screen_out, last_out,
                  valid_out, input ready_in);
  modport slave  (input x_proj, y_proj, color_proj, on_screen_out, last_out,
                  valid_out, output ready_in);
endinterface

// File: rtl/projection_stream_dot.sv
// One projection axis: registered products, then sum, floor shift and origin
// add into the output register. Both stages advance only when en is high.
module proj_dot #(
  parameter int N_BASIS   = 3,
  parameter int VEC_W     = 16,
  parameter int SCALAR_W  = 16,
  parameter int FRAC_BITS = 8,
  parameter int COORD_W   = 32,
  parameter int ORG_W     = 11
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [N_BASIS-1:0][VEC_W-1:0]     vec,
  input  logic [N_BASIS-1:0][SCALAR_W-1:0]  scalars,
  input  logic [ORG_W-1:0]                  origin,
  output logic signed [COORD_W-1:0]         coord
);
  localparam int P_W = VEC_W + SCALAR_W;

  logic signed [P_W-1:0]     prod_q [N_BASIS];
  logic signed [COORD_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_BASIS; i++) sum = sum + COORD_W'(prod_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BASIS; i++) prod_q[i] <= '0;
      coord <= '0;
    end else if (en) begin
      for (int i = 0; i < N_BASIS; i++)
        prod_q[i] <= P_W'($signed(vec[i])) * P_W'($signed(scalars[i]));
      // Origin is an unsigned screen position, so it is zero-extended.
      coord <= (sum >>> FRAC_BITS) + $signed(COORD_W'(origin));
    end
  end
endmodule

// File: rtl/projection_stream.sv
// Frame point buffer plus sweep FSM streaming every point through a 3-stage
// projection pipeline (RAM read, products, sum/shift/origin) to line_gen.
module projection_stream
  import projection_pkg::*;
#(
  parameter int N_BASIS  = N_BASIS_DEF,
  parameter int N_POINTS = 16,
  parameter int VEC_W    = 16,
  parameter int SCALAR_W = SCALAR_W_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int COORD_W  = 32,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  localparam int AW      = $clog2(N_POINTS),
  localparam int CNT_W   = AW + 1
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic signed [N_BASIS-1:0][VEC_W-1:0]   x_vec,
  input  logic signed [N_BASIS-1:0][VEC_W-1:0]   y_vec,
  input  logic [10:0]                            x_origin,
  input  logic [9:0]                             y_origin,
  input  logic                                   wr_en_in,
  input  logic [AW-1:0]                          wr_addr_in,
  input  logic signed [N_BASIS-1:0][SCALAR_W-1:0] wr_scalars_in,
  input  logic [COLOR_W-1:0]                     wr_color_in,
  input  logic [CNT_W-1:0]                       n_points_in,
  input  logic                                   start_in,
  projection_stream_if.master                    out_if,
  output logic                                   busy_out,
  output logic                                   done_out,
  output state_t                                 dbg_state
);
  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              count, rd_idx, n_clamped;
  logic [N_BASIS-1:0][VEC_W-1:0] sx_vec, sy_vec;
  logic [10:0]                   sx_org;
  logic [9:0]                    sy_org;
  point_t                        mem [N_POINTS];
  point_t                        rec_q;
  logic                          en, issue, issue_last;
  logic                          s1_v, s1_last, s2_v, s2_last;
  logic [COLOR_W-1:0]            s2_color;

  assign en         = !out_if.valid_out || out_if.ready_in;
  assign issue      = en && (state == RUN);
  assign issue_last = (rd_idx == count - CNT_W'(1));
  assign n_clamped  = (n_points_in > CNT_W'(N_POINTS)) ? CNT_W'(N_POINTS) : n_points_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = (n_clamped == '0) ? DONE : RUN;
      RUN:     if (issue && issue_last) state_nxt = DRAIN;
      DRAIN:   if (out_if.valid_out && out_if.ready_in && out_if.last_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_out  = (state == RUN) || (state == DRAIN);
    done_out  = (state == DONE);
    dbg_state = state;
  end

  // Snapshot of basis/origin keeps live input changes out of the current frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count  <= '0;
      rd_idx <= '0;
      sx_vec <= '0;
      sy_vec <= '0;
      sx_org <= '0;
      sy_org <= '0;
    end else if (state == IDLE && start_in) begin
      count  <= n_clamped;
      rd_idx <= '0;
      sx_vec <= x_vec;
      sy_vec <= y_vec;
      sx_org <= x_origin;
      sy_org <= y_origin;
    end else if (issue) begin
      rd_idx <= rd_idx + CNT_W'(1);
    end
  end

  // Buffer contents survive reset; it is only written while idle.
  always_ff @(posedge clk_in) begin
    if (wr_en_in && state == IDLE)
      mem[wr_addr_in] <= '{scalars: wr_scalars_in, color: wr_color_in};
    if (issue)
      rec_q <= mem[rd_idx[AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_v              <= 1'b0;
      s1_last           <= 1'b0;
      s2_v              <= 1'b0;
      s2_last           <= 1'b0;
      s2_color          <= '0;
      out_if.valid_out  <= 1'b0;
      out_if.last_out   <= 1'b0;
      out_if.color_proj <= '0;
    end else if (en) begin
      s1_v              <= issue;
      s1_last           <= issue && issue_last;
      s2_v              <= s1_v;
      s2_last           <= s1_last;
      s2_color          <= rec_q.color;
      out_if.valid_out  <= s2_v;
      out_if.last_out   <= s2_last;
      out_if.color_proj <= s2_color;
    end
  end

  proj_dot #(.N_BASIS(N_BASIS), .VEC_W(VEC_W), .SCALAR_W(SCALAR_W),
             .FRAC_BITS(FRAC_BITS), .COORD_W(COORD_W), .ORG_W(11)) u_dot_x (
    .clk(clk_in), .rst(rst_in), .en(en), .vec(sx_vec), .scalars(rec_q.scalars),
    .origin(sx_org), .coord(out_if.x_proj)
  );

  proj_dot #(.N_BASIS(N_BASIS), .VEC_W(VEC_W), .SCALAR_W(SCALAR_W),
             .FRAC_BITS(FRAC_BITS), .COORD_W(COORD_W), .ORG_W(10)) u_dot_y (
    .clk(clk_in), .rst(rst_in), .en(en), .vec(sy_vec), .scalars(rec_q.scalars),
    .origin(sy_org), .coord(out_if.y_proj)
  );

  assign out_if.on_screen_out = out_if.valid_out &&
    (out_if.x_proj >= 0) && (out_if.x_proj < COORD_W'(H_ACTIVE)) &&
    (out_if.y_proj >= 0) && (out_if.y_proj < COORD_W'(V_ACTIVE));
endmodule

// File: tb/tb_projection_stream.sv
// Bench for projection_stream: single-point vector table, then multi-point
// frames with backpressure, mid-sweep changes, edge counts and reset.
module tb_projection_stream;
  import projection_pkg::*;

  localparam int NB = 3;
  localparam int NP = 16;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b1;
  logic [NB-1:0][15:0]   x_vec, y_vec, wr_scalars_in;
  logic [10:0]           x_origin;
  logic [9:0]            y_origin;
  logic                  wr_en_in, start_in;
  logic [3:0]            wr_addr_in, wr_color_in;
  logic [4:0]            n_points_in;
  logic                  busy_out, done_out;
  state_t                dbg_state;

  projection_stream_if #(.COORD_W(32), .COLOR_W(4)) s_if ();

  projection_stream dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_vec(x_vec), .y_vec(y_vec),
    .x_origin(x_origin), .y_origin(y_origin), .wr_en_in(wr_en_in),
    .wr_addr_in(wr_addr_in), .wr_scalars_in(wr_scalars_in), .wr_color_in(wr_color_in),
    .n_points_in(n_points_in), .start_in(start_in), .out_if(s_if),
    .busy_out(busy_out), .done_out(done_out), .dbg_state(dbg_state)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0, done_cnt = 0, beat_cnt = 0, done_ref = 0;
  logic [69:0]         exp_q[$];
  logic [NB-1:0][15:0] mem_sc [NP];
  logic [3:0]          mem_col [NP];
  bit                  bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    int ox, oy;
    logic [NB-1:0][15:0] xv, yv, sc;
    int col, ex, ey;
    bit on;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0][15:0] v3(input int a, input int b, input int c);
    v3 = {a[15:0], b[15:0], c[15:0]};
  endfunction

  function automatic logic [NB-1:0][15:0] rnd3(input int lo, input int hi);
    int t;
    for (int i = 0; i < NB; i++) begin
      t = int'($urandom_range(0, hi - lo)) + lo;
      rnd3[i] = t[15:0];
    end
  endfunction

  // Reference projection in wide integer arithmetic.
  function automatic logic [69:0] model(input logic [NB-1:0][15:0] sc,
                                        input logic [3:0] col, input bit last);
    longint sx = 0, sy = 0, x, y;
    bit on;
    for (int i = 0; i < NB; i++) begin
      sx += longint'($signed(x_vec[i])) * longint'($signed(sc[i]));
      sy += longint'($signed(y_vec[i])) * longint'($signed(sc[i]));
    end
    x  = (sx >>> FRAC_BITS) + longint'(x_origin);
    y  = (sy >>> FRAC_BITS) + longint'(y_origin);
    on = (x >= 0) && (x < 1280) && (y >= 0) && (y < 720);
    model = {x[31:0], y[31:0], col, on, last};
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  logic [69:0] held;
  bit          stalled = 1'b0;
  always @(negedge clk_in) begin
    logic [69:0] beat;
    beat = {s_if.x_proj, s_if.y_proj, s_if.color_proj, s_if.on_screen_out, s_if.last_out};
    if (done_out) done_cnt++;
    if (rst_in) stalled = 1'b0;
    else begin
      if (stalled) begin
        chk("stall_valid", s_if.valid_out, 1);
        chk("stall_hold", beat, held);
      end
      if (s_if.valid_out && s_if.ready_in) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat act=%0h exp=none", beat);
        end else chk("beat", beat, exp_q.pop_front());
      end
      stalled = s_if.valid_out && !s_if.ready_in;
      held    = beat;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_point(input int idx, input logic [NB-1:0][15:0] sc, input logic [3:0] col);
    wr_en_in = 1'b1; wr_addr_in = idx[3:0]; wr_scalars_in = sc; wr_color_in = col;
    step();
    wr_en_in = 1'b0;
    mem_sc[idx] = sc; mem_col[idx] = col;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model(mem_sc[i], mem_col[i], i == n - 1));
  endtask

  task automatic start_frame(input int n);
    done_ref    = done_cnt;
    n_points_in = n[4:0];
    start_in    = 1'b1;
    step();
    start_in    = 1'b0;
  endtask

  task automatic finish_frame(input bit bp, input int budget, input string name);
    for (int k = 0; k < budget && done_cnt == done_ref; k++) begin
      s_if.ready_in = bp ? bp_pat[k % 4] : 1'b1;
      step();
    end
    s_if.ready_in = 1'b1;
    chk({name, "_done"}, done_cnt - done_ref, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic load_random(input int n);
    x_vec = rnd3(-100, 100); y_vec = rnd3(-100, 100);
    x_origin = 11'($urandom_range(0, 1279)); y_origin = 10'($urandom_range(0, 719));
    for (int i = 0; i < n; i++) write_point(i, rnd3(-2048, 2047), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0;
    tbl[0] = '{300, 300, v3(-50, 100, 0), v3(50, 0, -100), v3(0, 0, ONE), 1, 300, 200, 1'b1};
    tbl[1] = '{300, 300, v3(-50, 100, 0), v3(50, 0, -100), v3(128, -128, 0), 2, 225, 325, 1'b1};
    tbl[2] = '{10, 10, v3(-50, -100, 0), v3(50, 0, -100), v3(0, ONE, 0), 3, -90, 10, 1'b0};
    tbl[3] = '{100, 100, v3(0, 0, 3), v3(0, 0, -3), v3(0, 0, 85), 4, 100, 99, 1'b1};
    tbl[4] = '{1279, 719, v3(-50, 100, 0), v3(50, 0, -100), v3(0, 0, 0), 5, 1279, 719, 1'b1};
    tbl[5] = '{1280, 0, v3(-50, 100, 0), v3(50, 0, -100), v3(0, 0, 0), 6, 1280, 0, 1'b0};
    tbl[6] = '{0, 720, v3(-50, 100, 0), v3(50, 0, -100), v3(0, 0, 0), 7, 0, 720, 1'b0};
    tbl[7] = '{2047, 1023, v3(-50, 100, 0), v3(50, 0, -100), v3(0, 0, 0), 8, 2047, 1023, 1'b0};
    tbl[8] = '{5, 5, v3(0, 0, 0), v3(0, 0, -100), v3(0, 0, ONE), 9, 5, -95, 1'b0};

    wr_en_in = 1'b0; start_in = 1'b0; wr_addr_in = '0; wr_scalars_in = '0; wr_color_in = '0;
    n_points_in = '0; x_vec = '0; y_vec = '0; x_origin = '0; y_origin = '0;
    s_if.ready_in = 1'b1;
    repeat (3) step();
    chk("rst_valid", s_if.valid_out, 0);
    chk("rst_last", s_if.last_out, 0);
    chk("rst_on", s_if.on_screen_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_xyc", {s_if.x_proj, s_if.y_proj, s_if.color_proj}, 0);
    chk("rst_state", dbg_state, IDLE);
    rst_in = 1'b0;
    step();

    // Single-point vectors, including latency from issue to valid.
    for (int v = 0; v < 9; v++) begin
      x_vec = tbl[v].xv; y_vec = tbl[v].yv;
      x_origin = 11'(tbl[v].ox); y_origin = 10'(tbl[v].oy);
      write_point(0, tbl[v].sc, 4'(tbl[v].col));
      exp_q.push_back({32'(tbl[v].ex), 32'(tbl[v].ey), 4'(tbl[v].col), tbl[v].on, 1'b1});
      start_frame(1);
      chk("busy_run", busy_out, 1);
      lat = 0;
      while (!s_if.valid_out && lat < 10) begin
        step();
        lat++;
      end
      chk("latency", lat, 3);
      finish_frame(1'b0, 20, "vec");
    end

    // Backpressure 1,0,0,1 over four points.
    load_random(4);
    push_frame(4);
    b0 = beat_cnt;
    start_frame(4);
    finish_frame(1'b1, 100, "bp");
    chk("bp_beats", beat_cnt - b0, 4);

    // Mid-sweep live changes, restart attempt and write are all ignored.
    load_random(4);
    push_frame(4);
    b0 = beat_cnt;
    start_frame(4);
    x_vec = rnd3(-100, 100); x_origin = 11'd500;
    start_in = 1'b1; n_points_in = 5'd1;
    wr_en_in = 1'b1; wr_addr_in = 4'd0; wr_scalars_in = v3(ONE, ONE, ONE); wr_color_in = 4'hF;
    step();
    start_in = 1'b0; wr_en_in = 1'b0;
    finish_frame(1'b0, 100, "mid");
    chk("mid_beats", beat_cnt - b0, 4);
    push_frame(1);
    start_frame(1);
    finish_frame(1'b0, 20, "mid_buf");

    // Zero points: immediate done pulse, no beats.
    b0 = beat_cnt;
    start_frame(0);
    chk("zero_done_now", done_out, 1);
    chk("zero_busy", busy_out, 0);
    finish_frame(1'b0, 10, "zero");
    chk("zero_beats", beat_cnt - b0, 0);

    // Over-range count clamps to the buffer depth.
    load_random(NP);
    push_frame(NP);
    b0 = beat_cnt;
    start_frame(NP + 1);
    finish_frame(1'b0, 100, "clamp");
    chk("clamp_beats", beat_cnt - b0, NP);

    // Reset while draining aborts without a done pulse.
    load_random(4);
    push_frame(4);
    start_frame(4);
    for (int k = 0; k < 20 && dbg_state != DRAIN; k++) step();
    chk("reach_drain", dbg_state, DRAIN);
    rst_in = 1'b1;
    step();
    chk("rst_drain_valid", s_if.valid_out, 0);
    chk("rst_drain_state", dbg_state, IDLE);
    chk("rst_drain_busy", busy_out, 0);
    rst_in = 1'b0;
    exp_q.delete();
    repeat (8) step();
    chk("rst_no_done", done_cnt - done_ref, 0);
    chk("rst_idle_valid", s_if.valid_out, 0);

    // Buffer contents survive reset.
    push_frame(1);
    start_frame(1);
    finish_frame(1'b0, 20, "retain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
